// File: rtl/prng_pkg.sv
// Shared constants and types for the PRNG generator and its health-test buffer.
package prng_pkg;

    localparam int          PRNG_WIDTH         = 32;
    localparam logic [31:0] PRNG_DEFAULT_SEED  = 32'hACE1_2468;
    localparam int          PRNG_FIFO_DEPTH    = 8;
    localparam int          PRNG_STARTUP_WORDS = 16;
    localparam int          PRNG_RCT_CUTOFF    = 4;
    localparam int          PRNG_APT_WINDOW    = 64;
    localparam int          PRNG_APT_CUTOFF    = 48;

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        RUN     = 2'd1,
        FAIL    = 2'd2
    } prng_state_t;

    localparam logic [1:0] FAIL_NONE = 2'b00;
    localparam logic [1:0] FAIL_RCT  = 2'b01;
    localparam logic [1:0] FAIL_APT  = 2'b10;
    localparam logic [1:0] FAIL_BOTH = 2'b11;

endpackage

// File: rtl/prng_sync_fifo.sv
// First-word-fall-through synchronous FIFO; out_data reads as zero while empty.
module prng_sync_fifo
    import prng_pkg::*;
#(
    parameter int N     = PRNG_WIDTH,
    parameter int DEPTH = PRNG_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [N-1:0]             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [N-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign level   = count;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/prng_health_buffer.sv
// Online RCT/APT health tests on generator words, with a start-up discard period
// and a FWFT output buffer that is flushed whenever a test fails.
module prng_health_buffer
    import prng_pkg::*;
#(
    parameter int N             = PRNG_WIDTH,
    parameter int DEPTH         = PRNG_FIFO_DEPTH,
    parameter int STARTUP_WORDS = PRNG_STARTUP_WORDS,
    parameter int RCT_CUTOFF    = PRNG_RCT_CUTOFF,
    parameter int APT_WINDOW    = PRNG_APT_WINDOW,
    parameter int APT_CUTOFF    = PRNG_APT_CUTOFF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [N-1:0]           in_data,
    input  logic                   clear_fail,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_data,
    output logic                   fail,
    output logic [1:0]             fail_code,
    output logic [$clog2(DEPTH):0] level
);

    localparam int RCT_W = $clog2(RCT_CUTOFF) + 1;
    localparam int APT_W = $clog2(APT_CUTOFF) + 1;
    localparam int WIN_W = $clog2(APT_WINDOW) + 1;
    localparam int SU_W  = $clog2(STARTUP_WORDS) + 1;

    localparam logic [RCT_W-1:0] RCT_LIM = RCT_W'(RCT_CUTOFF);
    localparam logic [APT_W-1:0] APT_LIM = APT_W'(APT_CUTOFF);
    localparam logic [WIN_W-1:0] WIN_LIM = WIN_W'(APT_WINDOW);
    localparam logic [SU_W-1:0]  SU_LIM  = SU_W'(STARTUP_WORDS);
    localparam logic [RCT_W-1:0] RCT_ONE = RCT_W'(1);
    localparam logic [APT_W-1:0] APT_ONE = APT_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
    localparam logic [SU_W-1:0]  SU_ONE  = SU_W'(1);

    prng_state_t      state_q;
    logic [N-1:0]     prev_q;
    logic [RCT_W-1:0] rct_cnt_q, rct_next;
    logic             apt_ref_q;
    logic [APT_W-1:0] apt_cnt_q, apt_next;
    logic [WIN_W-1:0] win_cnt_q, win_next;
    logic [SU_W-1:0]  su_cnt_q, su_next;
    logic [1:0]       fail_code_q;

    logic sample, new_win, rct_fail, apt_fail, any_fail;
    logic push, pop, flush, fifo_full, fifo_empty;

    always_comb begin
        sample   = in_valid && (state_q != FAIL);
        rct_next = RCT_ONE;
        if (rct_cnt_q != '0 && in_data == prev_q)
            rct_next = (rct_cnt_q == '1) ? rct_cnt_q : rct_cnt_q + RCT_ONE;
        rct_fail = sample && (rct_next >= RCT_LIM);

        // A window count of zero means no window is open yet; a full one has just closed.
        new_win  = (win_cnt_q == '0) || (win_cnt_q >= WIN_LIM);
        win_next = WIN_ONE;
        apt_next = APT_ONE;
        if (!new_win) begin
            win_next = (win_cnt_q == '1) ? win_cnt_q : win_cnt_q + WIN_ONE;
            apt_next = apt_cnt_q;
            if (in_data[0] == apt_ref_q && apt_cnt_q != '1)
                apt_next = apt_cnt_q + APT_ONE;
        end
        apt_fail = sample && (apt_next >= APT_LIM);
        any_fail = rct_fail || apt_fail;

        su_next = (su_cnt_q == '1) ? su_cnt_q : su_cnt_q + SU_ONE;
        pop     = out_ready && !fifo_empty;
        push    = sample && (state_q == RUN) && !any_fail && (!fifo_full || pop);
        flush   = any_fail || ((state_q == FAIL) && clear_fail);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= STARTUP;
            prev_q      <= '0;
            rct_cnt_q   <= '0;
            apt_ref_q   <= 1'b0;
            apt_cnt_q   <= '0;
            win_cnt_q   <= '0;
            su_cnt_q    <= '0;
            fail_code_q <= FAIL_NONE;
        end else if (state_q == FAIL) begin
            if (clear_fail) begin
                state_q     <= STARTUP;
                fail_code_q <= FAIL_NONE;
            end
        end else if (in_valid) begin
            if (any_fail) begin
                state_q     <= FAIL;
                fail_code_q <= {apt_fail, rct_fail};
                prev_q      <= '0;
                rct_cnt_q   <= '0;
                apt_ref_q   <= 1'b0;
                apt_cnt_q   <= '0;
                win_cnt_q   <= '0;
                su_cnt_q    <= '0;
            end else begin
                prev_q    <= in_data;
                rct_cnt_q <= rct_next;
                apt_cnt_q <= apt_next;
                win_cnt_q <= win_next;
                if (new_win) apt_ref_q <= in_data[0];
                if (state_q == STARTUP) begin
                    su_cnt_q <= su_next;
                    if (su_next >= SU_LIM) state_q <= RUN;
                end
            end
        end
    end

    assign fail      = (state_q == FAIL);
    assign fail_code = fail_code_q;
    assign out_valid = !fifo_empty;

    prng_sync_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .flush     (flush),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

endmodule

// File: tb/tb_prng_health_buffer.sv
// Directed self-checking bench for prng_health_buffer with hand-computed expectations.
module tb_prng_health_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        clear_fail;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        fail;
    logic [1:0]  fail_code;
    logic [3:0]  level;

    int checks   = 0;
    int failures = 0;

    prng_health_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .clear_fail (clear_fail),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fail       (fail),
        .fail_code  (fail_code),
        .level      (level)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are read at that point too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; clear_fail = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_data got=%0h exp=0", out_data); end
        checks++; if (fail !== 1'b0) begin failures++; $display("[TB] FAIL reset_fail got=%0b exp=0", fail); end
        checks++; if (fail_code !== 2'b00) begin failures++; $display("[TB] FAIL reset_fail_code got=%0b exp=00", fail_code); end
        checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
    endtask

    task automatic test_startup();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(32'h1000_0000 + 32'(i));
            checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL startup_discard[%0d] got=%0b exp=0", i, out_valid); end
        end
        send(32'h1111_1111);
        idle();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL first_out_valid got=%0b exp=1", out_valid); end
        checks++; if (out_data !== 32'h1111_1111) begin failures++; $display("[TB] FAIL first_out_data got=%0h exp=11111111", out_data); end
        checks++; if (level !== 4'd1) begin failures++; $display("[TB] FAIL first_level got=%0d exp=1", level); end
    endtask

    task automatic test_rct();
        for (int i = 0; i < 3; i++) begin
            send(32'hAAAA_AAAA);
            checks++; if (fail !== 1'b0) begin failures++; $display("[TB] FAIL rct_early[%0d] got=%0b exp=0", i, fail); end
            checks++; if (level !== 4'(i + 2)) begin failures++; $display("[TB] FAIL rct_level[%0d] got=%0d exp=%0d", i, level, i + 2); end
        end
        send(32'hAAAA_AAAA);
        idle();
        checks++; if (fail !== 1'b1) begin failures++; $display("[TB] FAIL rct_fail got=%0b exp=1", fail); end
        checks++; if (fail_code !== 2'b01) begin failures++; $display("[TB] FAIL rct_code got=%0b exp=01", fail_code); end
        checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL rct_flush_level got=%0d exp=0", level); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rct_flush_valid got=%0b exp=0", out_valid); end
        for (int i = 0; i < 5; i++) send(32'hAAAA_AAAA);
        idle();
        tick();
        checks++; if (fail_code !== 2'b01) begin failures++; $display("[TB] FAIL rct_code_hold got=%0b exp=01", fail_code); end
        checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL fail_ignores_input got=%0d exp=0", level); end
    endtask

    task automatic test_apt();
        clear_fail = 1'b1; tick(); clear_fail = 1'b0;
        checks++; if (fail !== 1'b0) begin failures++; $display("[TB] FAIL clear1_fail got=%0b exp=0", fail); end
        checks++; if (fail_code !== 2'b00) begin failures++; $display("[TB] FAIL clear1_code got=%0b exp=00", fail_code); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(32'h2000_0000 + 32'(i));
        checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL apt_startup_level got=%0d exp=0", level); end
        // Fill the rest of the first 64-sample window with balanced bit 0.
        for (int i = 0; i < 48; i++) send(32'h3000_0000 + 32'(i));
        checks++; if (fail !== 1'b0) begin failures++; $display("[TB] FAIL apt_balanced got=%0b exp=0", fail); end
        for (int i = 0; i < 47; i++) send(32'h4000_0001 + 32'(2 * i));
        checks++; if (fail !== 1'b0) begin failures++; $display("[TB] FAIL apt_47 got=%0b exp=0", fail); end
        send(32'h4000_0001 + 32'(2 * 47));
        idle();
        checks++; if (fail !== 1'b1) begin failures++; $display("[TB] FAIL apt_fail got=%0b exp=1", fail); end
        checks++; if (fail_code !== 2'b10) begin failures++; $display("[TB] FAIL apt_code got=%0b exp=10", fail_code); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL apt_flush_valid got=%0b exp=0", out_valid); end
        clear_fail = 1'b1; tick(); clear_fail = 1'b0;
        checks++; if (fail !== 1'b0) begin failures++; $display("[TB] FAIL clear2_fail got=%0b exp=0", fail); end
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(32'h6000_0000 + 32'(i));
            checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL restart_discard[%0d] got=%0d exp=0", i, level); end
        end
        idle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(32'h5000_0000 + 32'(i));
            checks++; if (level !== 4'((i < 8) ? i + 1 : 8)) begin failures++; $display("[TB] FAIL bp_level[%0d] got=%0d exp=%0d", i, level, (i < 8) ? i + 1 : 8); end
        end
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 32'h5000_0000 + 32'(i)) begin failures++; $display("[TB] FAIL bp_order[%0d] got=%0h exp=%0h", i, out_data, 32'h5000_0000 + 32'(i)); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_dropped got=%0b exp=0", out_valid); end
        checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL bp_drained got=%0d exp=0", level); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(32'h7000_0000 + 32'(i));
        checks++; if (level !== 4'd8) begin failures++; $display("[TB] FAIL b2b_full got=%0d exp=8", level); end
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            send(32'h7100_0000 + 32'(k));
            exp_w = (k + 1 < 8) ? 32'h7000_0000 + 32'(k + 1) : 32'h7100_0000 + 32'(k - 7);
            checks++; if (level !== 4'd8) begin failures++; $display("[TB] FAIL b2b_level[%0d] got=%0d exp=8", k, level); end
            checks++; if (out_data !== exp_w) begin failures++; $display("[TB] FAIL b2b_head[%0d] got=%0h exp=%0h", k, out_data, exp_w); end
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        tick(); tick(); tick();
        out_ready = 1'b0;
        checks++; if (level !== 4'd5) begin failures++; $display("[TB] FAIL mid_level got=%0d exp=5", level); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL mid_reset_level got=%0d exp=0", level); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("[TB] FAIL mid_reset_data got=%0h exp=0", out_data); end
        checks++; if (fail !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_fail got=%0b exp=0", fail); end
        for (int i = 0; i < 16; i++) begin
            send(32'h8000_0000 + 32'(i));
            checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_restart[%0d] got=%0b exp=0", i, out_valid); end
        end
        send(32'h8ABC_DEF0);
        idle();
        checks++; if (out_data !== 32'h8ABC_DEF0 || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_first_word got=%0h exp=8abcdef0", out_data); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_rct();
        test_apt();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prng_health_buffer.md
Name: prng_health_buffer

Overview:
Downstream consumer of the 32-bit combined PRNG word. Runs continuous online health tests on every generated word: a repetition-count test on the full word and an adaptive-proportion test on bit 0. Words that pass, after a start-up discard period, are buffered in a small first-word-fall-through FIFO with a valid/ready output. Failures are latched and flush the buffer so that no suspect data leaves the block.

Parameters:
N, 32, data word width; matches generator width
DEPTH, 8, FIFO depth in words; power of 2, minimum 2
STARTUP_WORDS, 16, words tested but discarded after reset or clear_fail
RCT_CUTOFF, 4, run length of identical consecutive words that declares a failure
APT_WINDOW, 64, adaptive-proportion window length in samples
APT_CUTOFF, 48, bit-0 match count within one window that declares a failure

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_data carries a new generator word this cycle
in_data  input  N  generator word
clear_fail  input  1  single-cycle pulse; leave FAIL and restart start-up
out_valid  output  1  out_data holds a buffered word
out_ready  input  1  consumer accepts the word when out_valid && out_ready
out_data  output  N  head-of-FIFO word
fail  output  1  high while in FAIL
fail_code  output  2  01 = RCT, 10 = APT, 11 = both on the same sample; 00 when not failed
level  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: state STARTUP; out_valid 0; out_data 0; fail 0; fail_code 00; level 0; all counters 0; APT window empty.
- State machine: STARTUP -> RUN after STARTUP_WORDS valid samples that pass. STARTUP or RUN -> FAIL on any test failure. FAIL -> STARTUP on clear_fail. clear_fail is ignored outside FAIL.
- Tests evaluate only samples with in_valid = 1, in STARTUP and RUN. In FAIL, all samples are ignored.
- There is no backpressure to the generator.
- RCT:
  - The first sample after reset, clear, or FAIL exit loads prev and sets rct_cnt = 1.
  - A sample equal to prev increments rct_cnt. A different sample reloads prev and sets rct_cnt = 1.
  - A failure is declared when the incremented count reaches RCT_CUTOFF.
- APT:
  - The first sample of a window stores ref = in_data[0] and sets apt_cnt = 1 and a sample count of 1.
  - Each following sample increments the sample count, and increments apt_cnt when in_data[0] == ref.
  - A failure is declared when apt_cnt reaches APT_CUTOFF.
  - After APT_WINDOW samples the window closes, and the next sample opens a new window.
- Failure handling:
  - A failing sample is never pushed.
  - The cycle after the failing sample: fail = 1, fail_code is set, the FIFO is flushed (level 0, out_valid 0), and all test state is cleared.
  - fail_code holds its value until clear_fail.
- Push rules:
  - Push only in RUN, with in_valid = 1, on a passing sample, when not full or when a pop happens in the same cycle.
  - A sample arriving while full with no pop is dropped silently. The tests still consume it.
  - STARTUP samples are never pushed. The sample that completes the start-up count is not pushed either; pushing starts with the next sample.
- FIFO:
  - First-word fall-through: a word pushed at cycle t appears on out_data with out_valid = 1 at cycle t+1 when the FIFO was empty.
  - Pop happens on out_valid && out_ready. out_ready with an empty FIFO has no effect.
  - Simultaneous push and pop leaves level unchanged. Order is strict FIFO.
  - Read and write pointers wrap modulo DEPTH.
  - out_data holds its value while out_valid && !out_ready.
- Counter widths: rct_cnt, apt_cnt, the window count and the start-up count are each sized with clog2 of their limit +1. They saturate and never wrap.
- Reset or clear_fail mid-transfer discards FIFO contents with no partial-word output.

Decomposition:
- Shared package prng_pkg holds:
  - the state enum (STARTUP, RUN, FAIL);
  - the fail_code constants (FAIL_NONE, FAIL_RCT, FAIL_APT, FAIL_BOTH);
  - the default seed, width and cutoff constants shared with the generator.
- One natural sub-module, prng_sync_fifo (parameters N, DEPTH; ports push, pop, flush, full, empty, level). The health tests and the state machine stay in the top module.

Test Plan:
1. Reset, then 16 distinct words with in_valid = 1, then word 32'h11111111 -> no output for the first 16; out_valid = 1 with out_data = 32'h11111111 on the cycle after the 17th word.
2. After start-up, 32'hAAAAAAAA presented 4 consecutive cycles -> fail = 1 and fail_code = 01 on the cycle after the 4th; the first three words are in the FIFO before the flush; level = 0 and out_valid = 0 after the failure.
3. In RUN, 48 words with bit 0 = 1 and all words distinct -> fail_code = 10 on the cycle after the 48th; pulse clear_fail -> fail = 0, state STARTUP, 16 further words discarded.
4. out_ready = 0 with 10 passing words in RUN -> level saturates at 8; then out_ready = 1 -> exactly the first 8 words emerge in order; words 9 and 10 are lost.
5. FIFO full with out_ready = 1 and in_valid = 1 every cycle -> level stays 8 and throughput is one word per cycle.
6. reset asserted with level = 5 -> next cycle level = 0, out_valid = 0, fail = 0, STARTUP count restarts.
